// File: rtl/round_pkg.sv
// Shared types and helpers for the countdown round controller.
// Holds state encodings, BCD widths and the seconds-to-BCD constant function.
package round_pkg;

    localparam int BCD_W    = 4;
    localparam int DIGITS_W = 3 * BCD_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    // Only ever evaluated on parameters, so it folds away at elaboration.
    function automatic logic [DIGITS_W-1:0] secs_to_bcd(input int secs);
        logic [BCD_W-1:0] hund;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        hund = BCD_W'((secs / 100) % 10);
        tens = BCD_W'((secs / 10) % 10);
        ones = BCD_W'(secs % 10);
        return {hund, tens, ones};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Three-digit BCD down counter with synchronous load; load has priority over decrement.
// Saturates at 000 so a stray decrement can never wrap.
module bcd_down_counter
    import round_pkg::*;
(
    input  logic                clk_i,
    input  logic                load_i,
    input  logic [DIGITS_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic [DIGITS_W-1:0] digits_o,
    output logic                is_one_o
);

    logic [DIGITS_W-1:0] digits_q;
    logic [DIGITS_W-1:0] digits_d;

    always_comb begin
        digits_d = digits_q;
        if (load_i) begin
            digits_d = load_val_i;
        end else if (dec_i && (digits_q != '0)) begin
            if (digits_q[3:0] != 4'd0) begin
                digits_d[3:0] = digits_q[3:0] - 4'd1;
            end else begin
                digits_d[3:0] = 4'd9;
                if (digits_q[7:4] != 4'd0) begin
                    digits_d[7:4] = digits_q[7:4] - 4'd1;
                end else begin
                    digits_d[7:4]  = 4'd9;
                    digits_d[11:8] = digits_q[11:8] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        digits_q <= digits_d;
    end

    assign digits_o = digits_q;
    assign is_one_o = (digits_q == DIGITS_W'(1));

endmodule

// File: rtl/round_controller.sv
// Countdown round FSM (idle/run/pause/done) driving a BCD remaining-time display.
// Optional warning flag enabled by defining ROUND_CONTROLLER_WARN_EN.
module round_controller
    import round_pkg::*;
#(
    parameter int START_SECS = 120,
    parameter int WARN_SECS  = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                pause_i,
    input  logic                tick_i,
    output logic [DIGITS_W-1:0] digits_o,
    output logic                running_o,
    output logic                paused_o,
    output logic                done_o,
    output logic                warn_o,
    output logic [2:0]          state_o
);

    localparam logic [DIGITS_W-1:0] START_BCD = secs_to_bcd(START_SECS);
    localparam state_e START_ST = (START_SECS == 0) ? ST_DONE : ST_RUN;

    state_e state_q, state_d;
    logic   running_q, paused_q, done_q, warn_q, warn_d;
    logic   load, dec, is_one;
    logic [DIGITS_W-1:0] digits;

    // Reset reloads the counter, so the digit register needs no reset of its own.
    assign load = rst_i || (start_i && (state_q != ST_RUN));
    assign dec  = !rst_i && (state_q == ST_RUN) && tick_i && !pause_i;

    bcd_down_counter u_counter (
        .clk_i      (clk_i),
        .load_i     (load),
        .load_val_i (START_BCD),
        .dec_i      (dec),
        .digits_o   (digits),
        .is_one_o   (is_one)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = START_ST;
            ST_RUN: begin
                if (pause_i)               state_d = ST_PAUSE;
                else if (tick_i && is_one) state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (start_i)       state_d = START_ST;
                else if (!pause_i) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ROUND_CONTROLLER_WARN_EN
    localparam logic [DIGITS_W-1:0] WARN_BCD    = secs_to_bcd(WARN_SECS);
    localparam logic [DIGITS_W-1:0] WARN_BCD_P1 = secs_to_bcd(WARN_SECS + 1);

    // Predict the post-edge digit value so Warn lines up with Digits.
    always_comb begin
        warn_d = 1'b0;
        if ((state_d == ST_RUN) || (state_d == ST_PAUSE)) begin
            if (load)     warn_d = (START_BCD <= WARN_BCD);
            else if (dec) warn_d = (digits <= WARN_BCD_P1);
            else          warn_d = (digits <= WARN_BCD);
        end
    end
`else
    assign warn_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
            done_q    <= (state_d == ST_DONE);
            warn_q    <= warn_d;
        end
    end

    assign digits_o  = digits;
    assign running_o = running_q;
    assign paused_o  = paused_q;
    assign done_o    = done_q;
    assign warn_o    = warn_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller (START_SECS=120, WARN_SECS=10).
// Warn expectations follow ROUND_CONTROLLER_WARN_EN when the bench is built with it.
module tb_round_controller;

    localparam int WARN = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        tick = 1'b0;
    logic [11:0] digits;
    logic        running, paused, done, warn;
    logic [2:0]  state;

    typedef struct packed {
        logic [11:0] d;
        logic        r;
        logic        p;
        logic        dn;
        logic        w;
        logic [2:0]  s;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    secs;

    round_controller #(.START_SECS(120), .WARN_SECS(WARN)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .pause_i   (pause),
        .tick_i    (tick),
        .digits_o  (digits),
        .running_o (running),
        .paused_o  (paused),
        .done_o    (done),
        .warn_o    (warn),
        .state_o   (state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input logic r, input logic st, input logic pa, input logic tk,
                       input int es, input logic [2:0] est, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; start = st; pause = pa; tick = tk;
        @(posedge clk);
        #1;
        e.d  = to_bcd(es);
        e.r  = (est == 3'd1);
        e.p  = (est == 3'd2);
        e.dn = (est == 3'd3);
`ifdef ROUND_CONTROLLER_WARN_EN
        e.w  = ((est == 3'd1) || (est == 3'd2)) && (es <= WARN);
`else
        e.w  = 1'b0;
`endif
        e.s  = est;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check(input string nm, input string fld, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, "digits",  int'(digits),  int'(e.d));
            check(nm, "state",   int'(state),   int'(e.s));
            check(nm, "running", int'(running), int'(e.r));
            check(nm, "paused",  int'(paused),  int'(e.p));
            check(nm, "done",    int'(done),    int'(e.dn));
            check(nm, "warn",    int'(warn),    int'(e.w));
        end
    end

    task automatic tick_to(input int target, input string nm);
        while (secs > target) begin
            secs--;
            cyc(0, 0, 0, 1, secs, (secs == 0) ? 3'd3 : 3'd1, nm);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 120, 3'd0, "reset");
        cyc(0, 0, 1, 1, 120, 3'd0, "idle_ignores");
        cyc(0, 1, 0, 0, 120, 3'd1, "start");
        secs = 120;
        tick_to(0, "full_countdown");
        cyc(0, 0, 0, 0, 0, 3'd3, "done_hold");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 3'd3, "done_tick");
        cyc(0, 1, 0, 1, 120, 3'd1, "done_start_tick");
        secs = 120;
        cyc(0, 0, 0, 0, 120, 3'd1, "run_idle_cycle");
        tick_to(57, "to_057");
        cyc(0, 1, 0, 0, 57, 3'd1, "run_start_ignored");
        cyc(0, 0, 1, 0, 57, 3'd2, "pause_enter");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 57, 3'd2, "pause_tick_drop");
        cyc(0, 0, 0, 0, 57, 3'd1, "pause_release");
        secs = 56;
        cyc(0, 0, 0, 1, 56, 3'd1, "resume_tick");
        tick_to(31, "to_031");
        cyc(0, 0, 0, 1, 30, 3'd1, "tick_030");
        cyc(0, 0, 1, 1, 30, 3'd2, "tick_pause_same");
        cyc(0, 1, 1, 0, 120, 3'd1, "pause_start_reload");
        cyc(0, 0, 1, 0, 120, 3'd2, "repause");
        cyc(0, 0, 0, 0, 120, 3'd1, "unpause");
        secs = 120;
        tick_to(45, "to_045");
        cyc(1, 1, 0, 1, 120, 3'd0, "reset_mid_round");
        cyc(0, 0, 0, 1, 120, 3'd0, "idle_after_reset");
        cyc(0, 1, 0, 0, 120, 3'd1, "restart");
        secs = 120;
        tick_to(11, "to_011");
        tick_to(10, "warn_010");
        cyc(0, 0, 1, 0, 10, 3'd2, "warn_pause");
        cyc(0, 0, 0, 0, 10, 3'd1, "warn_resume");
        tick_to(0, "final_countdown");
        cyc(0, 0, 0, 1, 0, 3'd3, "done_no_warn");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
